// File: rtl/rst_sync.sv
// Reset synchronizer: clock-aligned, active-low reset whose release is delayed
// by NUM_Stages clean rising edges of CLK.
module rst_sync #(
  parameter int NUM_Stages = 2
) (
  input  logic CLK,
  input  logic Async_Reset,
  output logic sync_Reset
);

  if (NUM_Stages < 1) begin : g_bad_depth
    $error("rst_sync: NUM_Stages must be at least 1");
  end

  logic [NUM_Stages-1:0] stage;

  // A low sample flushes the whole chain; a high sample shifts a 1 in at stage 0.
  always_ff @(posedge CLK) begin
    if (!Async_Reset) begin
      stage <= '0;
    end else begin
      stage[0] <= 1'b1;
      for (int i = 1; i < NUM_Stages; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign sync_Reset = stage[NUM_Stages-1];

endmodule

// File: tb/tb_rst_sync.sv
// Self-checking bench for rst_sync: four chain depths share one reset request and
// are compared against a model that counts consecutive high samples.
module tb_rst_sync;

  logic clk;
  logic async_reset;
  logic sr1, sr2, sr3, sr6;
  logic [3:0] sr;
  int depth [4] = '{1, 2, 3, 6};

  int checks = 0;
  int errors = 0;

  // Model state: consecutive high samples since the last low one (or power-up).
  int hi_cnt = 0;
  bit seen_low = 0;
  int toggles6 = 0;

  rst_sync #(.NUM_Stages(1)) dut1 (.CLK(clk), .Async_Reset(async_reset), .sync_Reset(sr1));
  rst_sync #(.NUM_Stages(2)) dut2 (.CLK(clk), .Async_Reset(async_reset), .sync_Reset(sr2));
  rst_sync #(.NUM_Stages(3)) dut3 (.CLK(clk), .Async_Reset(async_reset), .sync_Reset(sr3));
  rst_sync #(.NUM_Stages(6)) dut6 (.CLK(clk), .Async_Reset(async_reset), .sync_Reset(sr6));

  assign sr = {sr6, sr3, sr2, sr1};

  // Rising edges at 10, 20, 30, ...
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5 clk = 1'b0;
      #5;
    end
  end

  always @(posedge clk) begin
    if (!async_reset) begin
      hi_cnt = 0;
      seen_low = 1;
    end else if (hi_cnt < 100000) begin
      hi_cnt = hi_cnt + 1;
    end
  end

  always @(sr6) toggles6 = toggles6 + 1;

  // Expected output of a depth-n synchronizer; X while still undefined after power-up.
  function automatic logic exp_of(int n);
    if (hi_cnt >= n) return 1'b1;
    if (seen_low) return 1'b0;
    return 1'bx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_powerup();
    logic e;
    async_reset = 1'b1;
    #6 async_reset = 1'b0;
    #1 async_reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        e = exp_of(depth[d]);
        if (e !== 1'bx) begin
          checks++;
          if (sr[d] !== e) begin
            errors++;
            $display("[TB] FAIL powerup depth=%0d edge=%0d got=%b want=%b", depth[d], k, sr[d], e);
          end
        end
      end
    end
    checks++;
    if (sr6 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL powerup_6th_edge got=%b want=1", sr6);
    end
  endtask

  task automatic test_assert_release();
    logic e;
    async_reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (sr !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL assert_low edge=%0d got=%b want=0000", k, sr);
      end
    end
    async_reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        e = exp_of(depth[d]);
        checks++;
        if (sr[d] !== e) begin
          errors++;
          $display("[TB] FAIL release depth=%0d edge=%0d got=%b want=%b", depth[d], k, sr[d], e);
        end
      end
    end
  endtask

  task automatic test_mid_release();
    int rise;
    async_reset = 1'b0;
    tick();
    async_reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (sr6 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_release_pre edge=%0d got=%b want=0", k, sr6);
      end
    end
    async_reset = 1'b0;
    tick();
    checks++;
    if (sr6 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_release_reassert got=%b want=0", sr6);
    end
    async_reset = 1'b1;
    rise = -1;
    for (int k = 1; k <= 20 && rise < 0; k++) begin
      tick();
      if (sr6 === 1'b1) rise = k;
    end
    checks++;
    if (rise !== 6) begin
      errors++;
      $display("[TB] FAIL mid_release_rise got=%0d edges want=6", rise);
    end
  endtask

  task automatic test_single_pulse();
    logic e;
    async_reset = 1'b1;
    repeat (8) tick();
    async_reset = 1'b0;
    tick();
    checks++;
    if (sr2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pulse_edge got=%b want=0", sr2);
    end
    async_reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = exp_of(2);
      checks++;
      if (sr2 !== e) begin
        errors++;
        $display("[TB] FAIL pulse_release edge=%0d got=%b want=%b", k, sr2, e);
      end
    end
  endtask

  task automatic test_depth_sweep();
    int rise [4];
    async_reset = 1'b1;
    repeat (8) tick();
    async_reset = 1'b0;
    tick();
    checks++;
    if (sr !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL sweep_assert_latency got=%b want=0000", sr);
    end
    tick();
    async_reset = 1'b1;
    for (int d = 0; d < 4; d++) rise[d] = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        if (rise[d] < 0 && sr[d] === 1'b1) rise[d] = k;
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rise[d] !== depth[d]) begin
        errors++;
        $display("[TB] FAIL sweep_release depth=%0d got=%0d edges want=%0d", depth[d], rise[d], depth[d]);
      end
    end
  endtask

  task automatic test_long_hold();
    int bad;
    async_reset = 1'b0;
    tick();
    toggles6 = 0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (sr !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0 || toggles6 != 0) begin
      errors++;
      $display("[TB] FAIL long_hold_low bad_samples=%0d toggles=%0d want 0 and 0", bad, toggles6);
    end
    async_reset = 1'b1;
    repeat (6) tick();
    toggles6 = 0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (sr !== 4'b1111) bad++;
    end
    checks++;
    if (bad != 0 || toggles6 != 0) begin
      errors++;
      $display("[TB] FAIL long_hold_high bad_samples=%0d toggles=%0d want 0 and 0", bad, toggles6);
    end
  endtask

  task automatic test_random();
    logic e;
    for (int k = 0; k < 400; k++) begin
      async_reset = ($urandom_range(0, 4) != 0);
      tick();
      for (int d = 0; d < 4; d++) begin
        e = exp_of(depth[d]);
        checks++;
        if (sr[d] !== e) begin
          errors++;
          $display("[TB] FAIL random depth=%0d cycle=%0d got=%b want=%b", depth[d], k, sr[d], e);
        end
      end
    end
  endtask

  initial begin
    test_powerup();
    test_assert_release();
    test_mid_release();
    test_single_pulse();
    test_depth_sweep();
    test_long_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
